// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3, one bit per clock); values above 9999 saturate.
// Latency: show/ovf/done update IN_W+1 clocks after the accepted start edge.
// Backpressure: start is ignored while busy; nothing is queued.
module bin2bcd_seq #(
  parameter int IN_W = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] bin,
  output logic            busy,
  output logic            done,
  output logic            ovf,
  output logic [15:0]     show
);

  localparam int            CW   = $clog2(IN_W + 1);
  localparam logic [CW-1:0] LAST = CW'(IN_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IN_W-1:0] shift_q, shift_d;
  logic [15:0]     bcd_q, bcd_d;
  logic [15:0]     bcd_adj;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_pend_q, ovf_pend_d;
  logic [15:0]     show_q, show_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;

  // Each nibble >= 5 gets +3 independently; no carry between digits.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    show_d     = show_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d    = bin;
          bcd_d      = 16'h0000;
          cnt_d      = '0;
          ovf_pend_d = (32'(bin) > 32'd9999);
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d   = {bcd_adj[14:0], shift_q[IN_W-1]};
        shift_d = {shift_q[IN_W-2:0], 1'b0};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        show_d  = ovf_pend_q ? 16'h9999 : bcd_q;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bcd_q      <= 16'h0000;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      show_q     <= 16'h0000;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      show_q     <= show_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign ovf  = ovf_q;
  assign show = show_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed scenarios plus randomized values against a decimal-digit model.
module tb_bin2bcd_seq;

  localparam int IN_W = 14;
  localparam int LAT  = IN_W + 1;

  logic            clk;
  logic            rst;
  logic            start;
  logic [IN_W-1:0] bin;
  logic            busy;
  logic            done;
  logic            ovf;
  logic [15:0]     show;

  int vectors;
  int miscompares;

  bin2bcd_seq #(.IN_W(IN_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .show  (show)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {ovf, show} from plain decimal arithmetic.
  function automatic logic [16:0] ref_conv(input int v);
    if (v > 9999) return {1'b1, 16'h9999};
    return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Pulse start with b, then wait (bounded) for done; reports latency and observed results.
  task automatic run_conv(input logic [IN_W-1:0] b, output int lat, output logic [15:0] s,
                          output logic o, output int busy_bad, output int held_bad);
    logic [15:0] prev;
    prev  = show;
    start = 1'b1;
    bin   = b;
    tick();
    start = 1'b0;
    bin   = IN_W'($urandom);
    lat = 0; busy_bad = 0; held_bad = 0;
    while (!done && lat < 40) begin
      if (!busy) busy_bad++;
      if (show !== prev) held_bad++;
      tick();
      lat++;
    end
    s = show;
    o = ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bin = '0;
    #3 rst = 1'b0;
    tick(); tick();
    vectors++;
    if ({busy, done, ovf, show} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_in: busy/done/ovf/show=%b/%b/%b/%h expected 0/0/0/0000", busy, done, ovf, show);
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if ({busy, done, ovf, show} !== 19'd0) begin
        miscompares++;
        $display("FAIL reset_idle cyc %0d: busy/done/ovf/show=%b/%b/%b/%h expected 0/0/0/0000", i, busy, done, ovf, show);
      end
    end
  endtask

  task automatic test_basic();
    int lat, bb, hb;
    logic [15:0] s;
    logic o;
    run_conv(IN_W'(1234), lat, s, o, bb, hb);
    vectors++;
    if (lat !== LAT) begin miscompares++; $display("FAIL basic_lat: got %0d expected %0d", lat, LAT); end
    vectors++;
    if (s !== 16'h1234) begin miscompares++; $display("FAIL basic_show: got %h expected 1234", s); end
    vectors++;
    if (o !== 1'b0) begin miscompares++; $display("FAIL basic_ovf: got %b expected 0", o); end
    vectors++;
    if (bb !== 0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL basic_busy: low-cycles %0d busy_at_done %b expected 0 0", bb, busy);
    end
    vectors++;
    if (hb !== 0) begin miscompares++; $display("FAIL basic_hold: show changed %0d times expected 0", hb); end
    tick();
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL basic_pulse: done=%b expected 0", done); end
  endtask

  task automatic test_back_to_back();
    int n1, n2, bad;
    start = 1'b1; bin = IN_W'(0);
    tick();
    n1 = 0;
    while (!done && n1 < 40) begin tick(); n1++; end
    vectors++;
    if (n1 !== LAT || show !== 16'h0000 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_first: lat %0d show %h ovf %b expected %0d 0000 0", n1, show, ovf, LAT);
    end
    bin = IN_W'(9999);
    tick();
    n2 = 1;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: busy=%b expected 1", busy); end
    start = 1'b0;
    bad = 0;
    while (!done && n2 < 40) begin
      if (show !== 16'h0000) bad++;
      tick();
      n2++;
    end
    vectors++;
    if (n2 !== LAT + 1) begin miscompares++; $display("FAIL b2b_spacing: got %0d expected %0d", n2, LAT + 1); end
    vectors++;
    if (show !== 16'h9999 || ovf !== 1'b0) begin
      miscompares++; $display("FAIL b2b_second: show %h ovf %b expected 9999 0", show, ovf);
    end
    vectors++;
    if (bad !== 0) begin miscompares++; $display("FAIL b2b_hold: show changed %0d cycles expected 0", bad); end
    tick();
  endtask

  task automatic test_saturate();
    int lat, bb, hb;
    logic [15:0] s;
    logic o;
    run_conv(IN_W'(12000), lat, s, o, bb, hb);
    vectors++;
    if (s !== 16'h9999 || o !== 1'b1 || lat !== LAT) begin
      miscompares++; $display("FAIL sat_hi: show %h ovf %b lat %0d expected 9999 1 %0d", s, o, lat, LAT);
    end
    tick();
    run_conv(IN_W'(5), lat, s, o, bb, hb);
    vectors++;
    if (s !== 16'h0005 || o !== 1'b0) begin
      miscompares++; $display("FAIL sat_clear: show %h ovf %b expected 0005 0", s, o);
    end
    tick();
  endtask

  task automatic test_ignore();
    int n, extra;
    start = 1'b1; bin = IN_W'(4321);
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      if (n == 6) begin start = 1'b1; bin = IN_W'(7); end
      else start = 1'b0;
      tick();
      n++;
    end
    start = 1'b0;
    vectors++;
    if (n !== LAT || show !== 16'h4321) begin
      miscompares++; $display("FAIL ignore_result: lat %0d show %h expected %0d 4321", n, show, LAT);
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) extra++;
    end
    vectors++;
    if (extra !== 0) begin miscompares++; $display("FAIL ignore_queued: %0d active cycles expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    int lat, bb, hb, dn;
    logic [15:0] s;
    logic o;
    start = 1'b1; bin = IN_W'(8765);
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({busy, done, ovf, show} !== 19'd0) begin
      miscompares++;
      $display("FAIL rstmid_async: busy/done/ovf/show=%b/%b/%b/%h expected 0/0/0/0000", busy, done, ovf, show);
    end
    tick(); tick();
    rst = 1'b1;
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) dn++;
    end
    vectors++;
    if (dn !== 0 || show !== 16'h0000) begin
      miscompares++; $display("FAIL rstmid_discard: active %0d show %h expected 0 0000", dn, show);
    end
    run_conv(IN_W'(42), lat, s, o, bb, hb);
    vectors++;
    if (s !== 16'h0042 || o !== 1'b0 || lat !== LAT) begin
      miscompares++; $display("FAIL rstmid_after: show %h ovf %b lat %0d expected 0042 0 %0d", s, o, lat, LAT);
    end
    tick();
  endtask

  task automatic test_random();
    int lat, bb, hb, v;
    logic [15:0] s;
    logic o;
    logic [16:0] exp;
    for (int i = 0; i < 30; i++) begin
      v   = (i % 5 == 0) ? int'($urandom_range(9990, 10010)) : int'($urandom_range(0, (1 << IN_W) - 1));
      exp = ref_conv(v);
      run_conv(IN_W'(v), lat, s, o, bb, hb);
      vectors++;
      if (s !== exp[15:0]) begin miscompares++; $display("FAIL rand_show bin=%0d: got %h expected %h", v, s, exp[15:0]); end
      vectors++;
      if (o !== exp[16]) begin miscompares++; $display("FAIL rand_ovf bin=%0d: got %b expected %b", v, o, exp[16]); end
      vectors++;
      if (lat !== LAT || bb !== 0 || hb !== 0) begin
        miscompares++; $display("FAIL rand_timing bin=%0d: lat %0d busy_low %0d held %0d expected %0d 0 0", v, lat, bb, hb, LAT);
      end
      repeat (i % 3) tick();
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturate();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Iterative binary-to-BCD converter (shift-and-add-3, one bit per clock) that produces the 16-bit 4-digit BCD word driving the `show` input of the seven-segment display driver. It sits directly upstream of the display. It takes a magnitude or bin index from the FFT datapath on a start strobe. The converted word is held stable between conversions, so the display never shows a partial result.

Parameters:
IN_W, 14, width of binary input; legal range 4..16; values above 9999 saturate.

Ports:
clk    input   1     system clock, rising edge
rst    input   1     asynchronous reset, active-low (rst=0 resets)
start  input   1     request conversion of bin; sampled on rising clk edge, only honoured in IDLE
bin    input   IN_W  unsigned binary value, sampled on the accepted start edge only
busy   output  1     high while a conversion is in progress (state != IDLE)
done   output  1     one-cycle pulse; show/ovf updated on the same edge
ovf    output  1     high if last accepted bin > 9999; updated with done
show   output  16    BCD result {thousands,hundreds,tens,units}; held until next done

Behaviour:
- Reset (rst=0, async): state=IDLE, show=16'h0000, done=0, ovf=0, busy=0, internal shift/BCD regs and counter cleared. Any in-flight conversion is discarded; no done is produced for it.
- States: IDLE, SHIFT, DONE (2-bit encoding; unused codes go to IDLE).
- IDLE:
  - On edge with start=1, capture bin into shift reg.
  - Clear the 16-bit BCD accumulator and bit counter.
  - Latch ovf_pend = (bin > 9999).
  - Go to SHIFT.
- SHIFT, one step per clock:
  - Every BCD nibble >= 5 gets +3 (4-bit add; no carry between nibbles).
  - Then the {bcd, shift} concatenation shifts left by 1; the bin MSB enters the BCD LSB.
  - The counter increments.
  - After exactly IN_W steps, go to DONE.
- DONE (single cycle):
  - On the edge leaving DONE: show <= ovf_pend ? 16'h9999 : bcd.
  - ovf <= ovf_pend; done <= 1; state -> IDLE.
  - done returns to 0 on the following edge.
- Latency: start accepted at edge k.
  - Shift steps occur on edges k+1..k+IN_W.
  - show/ovf/done update at edge k+IN_W+1 (15 cycles for IN_W=14).
  - busy is high from edge k to edge k+IN_W+1.
- start while busy (SHIFT or DONE, including the done-pulse edge): ignored, not queued. Upstream must wait for busy=0.
- start held high continuously: a new conversion is accepted on the first IDLE edge, i.e. one cycle after each done. Throughput is one result per IN_W+2 cycles.
- bin changes during a conversion: no effect (sampled at start only).
- show changes only on the done edge or on reset; it never shows intermediate values.
- Saturation: the compare uses full IN_W width. For IN_W <= 13, ovf is constantly 0.
- The BCD accumulator is 16 bits wide; for IN_W=16 it may hold garbage above 9999, which is masked by saturation.

Test Plan:
- Reset release, no start → show=0x0000, ovf=0, done=0, busy=0 indefinitely.
- bin=1234, start 1 cycle → busy for 15 cycles; done pulse exactly 15 cycles after start edge; show=0x1234, ovf=0.
- bin=0 then bin=9999 (back-to-back, start held high) → show=0x0000 with done, 1 IDLE cycle, then show=0x9999 with ovf=0; second done 16 cycles after first.
- bin=12000 → done with show=0x9999, ovf=1. Next bin=5 → show=0x0005, ovf=0.
- Conversion of bin=4321 in progress; start pulsed with bin=7 at step 6 → ignored; show=0x4321 at normal done time; no second done.
- Conversion of 8765 running, rst=0 asynchronously mid-step for 2 cycles → show=0x0000, busy=0 immediately, no done. After release, bin=42 converts to show=0x0042.
